// File: rtl/edge_meter.sv
// Edge meter: synchronizes an asynchronous input, reports rise/fall pulses, counts rising edges
// and measures the period between them. Define EDGE_METER_GLITCH_FILTER_EN for a 2-cycle filter.
module edge_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] TimerMax = '1;

  typedef enum logic {StIdle, StRun} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   det;
  logic                   det_d_q;
  logic                   acc_rise, acc_fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             pv_q, pv_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer and edge-detect history are never cleared by clr, so no edge appears on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      det_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in};
      det_d_q <= det;
    end
  end

`ifdef EDGE_METER_GLITCH_FILTER_EN
  logic hold_q, filt_q;

  // Accept a new level only once s has shown it on two consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hold_q <= s;
      if (s == hold_q) begin
        filt_q <= s;
      end
    end
  end

  assign det = filt_q;
`else
  assign det = s;
`endif

  assign acc_rise = det & ~det_d_q;
  assign acc_fall = ~det & det_d_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    pv_d     = 1'b0;
    rise_d   = acc_rise;
    fall_d   = acc_fall;
    if (clr) begin
      state_d  = StIdle;
      timer_d  = '0;
      cnt_d    = '0;
      period_d = '0;
      ovf_d    = 1'b0;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          timer_d = '0;
          if (acc_rise) begin
            state_d = StRun;
            timer_d = {{(CNT_W-1){1'b0}}, 1'b1};
            cnt_d   = cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (acc_rise) begin
            // A saturated timer already holds the maximum, so it doubles as the clamped period.
            period_d = timer_q;
            pv_d     = 1'b1;
            timer_d  = {{(CNT_W-1){1'b0}}, 1'b1};
            cnt_d    = cnt_q + 1'b1;
          end else if (timer_q != TimerMax) begin
            timer_d = timer_q + 1'b1;
            if (timer_d == TimerMax) begin
              ovf_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      pv_q     <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      pv_q     <= pv_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign rise       = rise_q;
  assign fall       = fall_q;
  assign edge_cnt   = cnt_q;
  assign period     = period_q;
  assign period_vld = pv_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_edge_meter.sv
// Directed bench for edge_meter: a 16-bit and a 4-bit instance share one stimulus stream.
module tb_edge_meter;

`ifdef EDGE_METER_GLITCH_FILTER_EN
  localparam int LAT = 2 + 1 + 2;
`else
  localparam int LAT = 2 + 1;
`endif

  logic clk = 1'b0;
  logic rst_n, in, clr;

  logic        rise, fall, period_vld, overflow;
  logic [15:0] edge_cnt, period;
  logic        rise4, fall4, period_vld4, overflow4;
  logic [3:0]  edge_cnt4, period4;

  int n_cmp = 0;
  int n_err = 0;
  int rise_total = 0, fall_total = 0, pv_total = 0, both_total = 0;
  int rise_base, fall_base, pv_base;

  always #5 clk = ~clk;

  edge_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .clr(clr),
    .rise(rise), .fall(fall), .edge_cnt(edge_cnt), .period(period),
    .period_vld(period_vld), .overflow(overflow)
  );

  edge_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in(in), .clr(clr),
    .rise(rise4), .fall(fall4), .edge_cnt(edge_cnt4), .period(period4),
    .period_vld(period_vld4), .overflow(overflow4)
  );

  always @(posedge clk) begin
    rise_total <= rise_total + int'(rise);
    fall_total <= fall_total + int'(fall);
    pv_total   <= pv_total + int'(period_vld);
    both_total <= both_total + int'(rise & fall);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic snap();
    rise_base = rise_total;
    fall_base = fall_total;
    pv_base   = pv_total;
  endtask

  task automatic toggles(input int n);
    for (int i = 0; i < n; i++) begin
      in = 1'b1;
      tick(4);
      in = 1'b0;
      tick(4);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in    = 1'b0;
    clr   = 1'b0;
    tick(3);
    check("rst_rise", 32'(rise), 0);
    check("rst_fall", 32'(fall), 0);
    check("rst_edge_cnt", 32'(edge_cnt), 0);
    check("rst_period", 32'(period), 0);
    check("rst_period_vld", 32'(period_vld), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    tick(2);

    // Exact rise/fall latency.
    in = 1'b1;
    tick(LAT - 1);
    check("lat_rise_early", 32'(rise), 0);
    tick(1);
    check("lat_rise", 32'(rise), 1);
    check("lat_edge_cnt", 32'(edge_cnt), 1);
    check("lat_first_no_pv", 32'(period_vld), 0);
    tick(1);
    check("lat_rise_one_cycle", 32'(rise), 0);
    in = 1'b0;
    tick(LAT);
    check("lat_fall", 32'(fall), 1);
    check("lat_fall_no_rise", 32'(rise), 0);
    tick(1);
    check("lat_fall_one_cycle", 32'(fall), 0);
    check("fall_no_count", 32'(edge_cnt), 1);
    do_clr();
    check("clr_edge_cnt", 32'(edge_cnt), 0);

    // Five rises, period 8.
    snap();
    toggles(5);
    tick(LAT + 2);
    check("t1_edge_cnt", 32'(edge_cnt), 5);
    check("t1_period", 32'(period), 8);
    check("t1_pv_pulses", 32'(pv_total - pv_base), 4);
    check("t1_rises", 32'(rise_total - rise_base), 5);
    check("t1_falls", 32'(fall_total - fall_base), 5);
    check("t1_overflow", 32'(overflow), 0);
    check("t1_period4", 32'(period4), 8);
    check("t1_overflow4", 32'(overflow4), 0);

    // 4-bit timer saturation.
    do_clr();
    in = 1'b1;
    tick(LAT);
    check("t2_rise", 32'(rise), 1);
    in = 1'b0;
    tick(13);
    check("t2_ovf4_at14", 32'(overflow4), 0);
    tick(1);
    check("t2_ovf4_at15", 32'(overflow4), 1);
    tick(6);
    in = 1'b1;
    tick(LAT);
    check("t2_pv4", 32'(period_vld4), 1);
    check("t2_period4_sat", 32'(period4), 15);
    check("t2_ovf4_sticky", 32'(overflow4), 1);
    check("t2_period16", 32'(period), 32'(LAT + 20));
    check("t2_ovf16", 32'(overflow), 0);

    // clr colliding with a rise.
    do_clr();
    in = 1'b0;
    tick(4);
    toggles(3);
    check("t3_edge_cnt3", 32'(edge_cnt), 3);
    in = 1'b1;
    tick(LAT - 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t3_clr_edge_cnt", 32'(edge_cnt), 0);
    check("t3_clr_rise", 32'(rise), 0);
    check("t3_clr_pv", 32'(period_vld), 0);
    check("t3_clr_period", 32'(period), 0);
    snap();
    tick(4);
    check("t3_no_spurious_cnt", 32'(edge_cnt), 0);
    check("t3_no_spurious_rise", 32'(rise_total - rise_base), 0);
    in = 1'b0;
    tick(4);
    in = 1'b1;
    tick(3);
    in = 1'b0;
    tick(3);
    in = 1'b1;
    tick(LAT);
    check("t3_pv", 32'(period_vld), 1);
    check("t3_period6", 32'(period), 6);
    check("t3_edge_cnt2", 32'(edge_cnt), 2);

    // 4-bit edge counter wrap.
    in = 1'b0;
    tick(4);
    do_clr();
    toggles(17);
    tick(LAT);
    check("t4_cnt4_wrap", 32'(edge_cnt4), 1);
    check("t4_ovf4", 32'(overflow4), 0);
    check("t4_cnt16", 32'(edge_cnt), 17);

    // Asynchronous reset mid-run, input high through release.
    do_clr();
    toggles(7);
    tick(LAT);
    check("t5_cnt7", 32'(edge_cnt), 7);
    in = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_cnt", 32'(edge_cnt), 0);
    check("t5_async_period", 32'(period), 0);
    check("t5_async_rise", 32'(rise), 0);
    check("t5_async_pv", 32'(period_vld), 0);
    check("t5_async_ovf4", 32'(overflow4), 0);
    tick(3);
    rst_n = 1'b1;
    snap();
    tick(LAT + 6);
    check("t5_one_rise", 32'(rise_total - rise_base), 1);
    check("t5_cnt1", 32'(edge_cnt), 1);
    check("t5_no_pv", 32'(pv_total - pv_base), 0);

`ifdef EDGE_METER_GLITCH_FILTER_EN
    in = 1'b0;
    tick(10);
    do_clr();
    snap();
    in = 1'b1;
    tick(1);
    in = 1'b0;
    tick(10);
    check("flt_glitch_rise", 32'(rise_total - rise_base), 0);
    check("flt_glitch_fall", 32'(fall_total - fall_base), 0);
    snap();
    in = 1'b1;
    tick(3);
    in = 1'b0;
    tick(10);
    check("flt_pulse_rise", 32'(rise_total - rise_base), 1);
    check("flt_pulse_fall", 32'(fall_total - fall_base), 1);
`endif

    check("never_rise_and_fall", 32'(both_total), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/edge_meter.md
EDGE_METER -- requirements
Module: edge_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of edge counter and period/timer registers (legal 4..32).
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on input in (legal 2..4).
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port in  input  1  monitored signal (invertor output), asynchronous to clk.
REQ-006 Port clr  input  1  synchronous clear of counters/state, active-high.
REQ-007 Port rise  output  1  one-cycle pulse per accepted rising edge of in.
REQ-008 Port fall  output  1  one-cycle pulse per accepted falling edge of in.
REQ-009 Port edge_cnt  output  CNT_W  count of accepted rising edges.
REQ-010 Port period  output  CNT_W  clk cycles between last two accepted rising edges.
REQ-011 Port period_vld  output  1  one-cycle pulse when period updates.
REQ-012 Port overflow  output  1  sticky flag, period timer saturated.

Function
REQ-013 in passes through SYNC_STAGES flops; s = last synchronizer stage; s_d = s delayed one cycle.
REQ-014 rise = s & ~s_d, fall = ~s & s_d, registered: pulse appears SYNC_STAGES+1 rising clk edges after in change is first sampled.
REQ-015 FSM states IDLE, RUN; reset and clr enter IDLE.
REQ-016 IDLE: timer held 0; on accepted rise -> RUN, timer <= 1, edge_cnt += 1, no period_vld.
REQ-017 RUN, no rise: timer <= timer+1, saturating at 2^CNT_W-1; reaching saturation sets overflow.
REQ-018 RUN, rise: period <= timer, period_vld pulses same cycle as period update, timer <= 1, edge_cnt += 1.
REQ-019 Rise while timer saturated: period <= 2^CNT_W-1, overflow stays 1.
REQ-020 edge_cnt wraps modulo 2^CNT_W, no flag.
REQ-021 clr priority over simultaneous rise: edge_cnt, period, timer, overflow <= 0, state IDLE, rise/fall/period_vld 0 next cycle; the rise is discarded.
REQ-022 clr does not reset synchronizer flops; s_d <= s during clr so no spurious edge after clr release.
REQ-023 fall has no effect on timer, edge_cnt, or FSM.
REQ-024 rise and fall never both 1 in same cycle.

Reset
REQ-025 rst_n low: all flops incl. synchronizer <= 0 immediately; rise, fall, period_vld, overflow = 0; edge_cnt, period = 0; state IDLE.
REQ-026 rst_n deassertion mid-operation: first edge accepted only after synchronizer refill; in held 1 through reset release yields exactly one rise.

Configuration
REQ-027 Macro EDGE_METER_GLITCH_FILTER_EN defined: s must hold new value for 2 consecutive cycles before accepted; pulses of width 1 clk on s ignored; rise/fall latency +2 cycles.
REQ-028 Macro undefined: no filter, latency per REQ-014, every s transition accepted.

Verification
REQ-029 Reset, in toggles every 4 clk cycles, 5 rises -> edge_cnt=5, period=8, four period_vld pulses, overflow=0.
REQ-030 CNT_W=4, in held 0 for 20 cycles after one rise -> overflow=1 at timer=15; next rise -> period=15.
REQ-031 clr asserted same cycle as rise, edge_cnt=3 -> edge_cnt=0, state IDLE, no period_vld; next two rises 6 apart -> period=6.
REQ-032 CNT_W=4, 17 rises -> edge_cnt=1 (wrap), no overflow.
REQ-033 rst_n pulsed low mid-RUN with edge_cnt=7 -> all outputs 0 asynchronously; in=1 through release -> exactly one rise, edge_cnt=1.
REQ-034 With EDGE_METER_GLITCH_FILTER_EN: 1-cycle high glitch on in -> no rise/fall; 3-cycle high pulse -> one rise, one fall.
